ppu_vram_fetch_sequencer: RTL and testbench

- Owns the PPU VRAM bus. Converts the registered per-dot enables from the render timing block into 2-dot address/read cycles for background tiles (NT, AT, PT low, PT high), sprite pattern fetches and dummy NT fetches.
- Arbitrates CPU $2007 accesses into idle bus time.
- Delivers latched tile bytes to the background/sprite shifters.
- Sits between the render timing block, the loopy-v register and the external VRAM/CHR bus.

---
 rtl/ppu_vram_fetch_sequencer.sv | 178 +++++++++++++++++
 tb/tb_ppu_vram_fetch_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_vram_fetch_sequencer.sv
// ============================================================================
// ppu_vram_fetch_sequencer : PPU VRAM bus owner; 2-dot BG/sprite/dummy fetches
// with CPU $2007 accesses slotted into idle bus time.      Rev 1.0
// ============================================================================
`default_nettype none
module ppu_vram_fetch_sequencer #(
  parameter int ADDR_W       = 14,
  parameter bit CPU_ABORT_EN = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clock_EN,
  input  logic              backgroundFetch_EN,
  input  logic              spriteFetch_EN,
  input  logic              dummyFetch_EN,
  input  logic [14:0]       vramAddr,
  input  logic              bgPatternTable,
  input  logic              sprPatternTable,
  input  logic              spriteSize16,
  input  logic [7:0]        spriteTile,
  input  logic [3:0]        spriteRow,
  input  logic              cpuReq,
  input  logic              cpuWrite,
  input  logic [ADDR_W-1:0] cpuAddr,
  input  logic [7:0]        cpuWData,
  output logic              cpuAck,
  output logic [7:0]        cpuRData,
  output logic [ADDR_W-1:0] ppuAddr,
  output logic              ppuALE,
  output logic              ppuRD_n,
  output logic              ppuWR_n,
  output logic [7:0]        ppuDataOut,
  output logic              ppuDataOE,
  input  logic [7:0]        ppuDataIn,
  output logic [7:0]        ntByte,
  output logic [1:0]        atBits,
  output logic [7:0]        ptLow,
  output logic [7:0]        ptHigh,
  output logic              bgTileValid,
  output logic [7:0]        spritePtLow,
  output logic [7:0]        spritePtHigh,
  output logic [2:0]        spriteIndex,
  output logic              spriteDataValid
);

  typedef enum logic [1:0] {SRC_NONE = 2'd0, SRC_BG = 2'd1, SRC_SPR = 2'd2, SRC_DUMMY = 2'd3} src_t;
  typedef enum logic [1:0] {C_IDLE = 2'd0, C_ADDR = 2'd1, C_DATA = 2'd2} cpu_st_t;

  src_t        r_src, w_src, r_cap_src;
  cpu_st_t     r_cst, w_cst_nxt;
  logic [2:0]  r_phase, w_phase;
  logic [1:0]  w_slot, r_cap_slot;
  logic [14:0] r_vlat;
  logic        r_cap_en;
  logic [13:0] w_nt_addr, w_raddr;
  logic [7:0]  w_at_shift;
  logic        w_render, w_abort, w_cpu_done;
  logic        w_unused;

  assign w_unused = ^{r_vlat[5], r_vlat[0]};

  // Source priority, phase restart on source change, and render address mux.
  always_comb begin
    w_src = SRC_NONE;
    if (dummyFetch_EN)           w_src = SRC_DUMMY;
    else if (backgroundFetch_EN) w_src = SRC_BG;
    else if (spriteFetch_EN)     w_src = SRC_SPR;
    w_phase   = (w_src != r_src) ? 3'd0 : r_phase;
    w_slot    = w_phase[2:1];
    w_nt_addr = {2'b10, vramAddr[11:0]};
    w_raddr   = w_nt_addr;
    case (w_src)
      SRC_BG: begin
        if (w_slot == 2'd1)
          w_raddr = {2'b10, r_vlat[11:10], 4'b1111, r_vlat[9:7], r_vlat[4:2]};
        else if (w_slot[1])
          w_raddr = {1'b0, bgPatternTable, ntByte, w_slot[0], r_vlat[14:12]};
      end
      SRC_SPR: begin
        if (w_slot[1] && spriteSize16)
          w_raddr = {1'b0, spriteTile[0], spriteTile[7:1], spriteRow[3], w_slot[0], spriteRow[2:0]};
        else if (w_slot[1])
          w_raddr = {1'b0, sprPatternTable, spriteTile, w_slot[0], spriteRow[2:0]};
      end
      default: ;
    endcase
    w_render   = (w_src != SRC_NONE) && (CPU_ABORT_EN || (r_cst == C_IDLE));
    w_at_shift = ppuDataIn >> {r_vlat[6], r_vlat[1], 1'b0};
  end

  always_comb begin
    w_cst_nxt  = r_cst;
    w_cpu_done = 1'b0;
    w_abort    = CPU_ABORT_EN && (w_src != SRC_NONE);
    case (r_cst)
      C_IDLE:  if ((w_src == SRC_NONE) && cpuReq) w_cst_nxt = C_ADDR;
      C_ADDR:  w_cst_nxt = w_abort ? C_IDLE : C_DATA;
      C_DATA: begin
        w_cst_nxt  = C_IDLE;
        w_cpu_done = !w_abort;
      end
      default: w_cst_nxt = C_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)         r_cst <= C_IDLE;
    else if (clock_EN) r_cst <= w_cst_nxt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_src <= SRC_NONE;   r_phase <= 3'd0;     r_vlat <= 15'd0;
      r_cap_en <= 1'b0;    r_cap_src <= SRC_NONE; r_cap_slot <= 2'd0;
      ntByte <= 8'd0;      atBits <= 2'd0;      ptLow <= 8'd0;     ptHigh <= 8'd0;
      spritePtLow <= 8'd0; spritePtHigh <= 8'd0; spriteIndex <= 3'd0;
      bgTileValid <= 1'b0; spriteDataValid <= 1'b0;
      cpuAck <= 1'b0;      cpuRData <= 8'd0;
      ppuAddr <= '0;       ppuALE <= 1'b0;      ppuRD_n <= 1'b1;   ppuWR_n <= 1'b1;
      ppuDataOut <= 8'd0;  ppuDataOE <= 1'b0;
    end else if (clock_EN) begin
      r_src <= w_src;
      if (w_src != SRC_NONE) r_phase <= w_phase + 3'd1;
      if ((w_src == SRC_BG) && (w_phase == 3'd0)) r_vlat <= vramAddr;

      // Bus data belongs to the read phase presented during the previous dot.
      bgTileValid     <= 1'b0;
      spriteDataValid <= 1'b0;
      if (r_cap_en && (r_cap_src == SRC_BG)) begin
        case (r_cap_slot)
          2'd0: ntByte <= ppuDataIn;
          2'd1: atBits <= w_at_shift[1:0];
          2'd2: ptLow  <= ppuDataIn;
          default: begin
            ptHigh      <= ppuDataIn;
            bgTileValid <= 1'b1;
          end
        endcase
      end else if (r_cap_en && (r_cap_src == SRC_SPR)) begin
        if (r_cap_slot == 2'd2) spritePtLow <= ppuDataIn;
        if (r_cap_slot == 2'd3) begin
          spritePtHigh    <= ppuDataIn;
          spriteDataValid <= 1'b1;
        end
      end
      if ((w_src == SRC_SPR) && (r_src != SRC_SPR)) spriteIndex <= 3'd0;
      else if (spriteDataValid)                     spriteIndex <= spriteIndex + 3'd1;

      cpuAck <= w_cpu_done;
      if (w_cpu_done && !cpuWrite) cpuRData <= ppuDataIn;

      r_cap_en   <= w_render && w_phase[0];
      r_cap_src  <= w_src;
      r_cap_slot <= w_slot;

      ppuALE    <= 1'b0;
      ppuRD_n   <= 1'b1;
      ppuWR_n   <= 1'b1;
      ppuDataOE <= 1'b0;
      if (w_render) begin
        ppuALE  <= ~w_phase[0];
        ppuRD_n <= ~w_phase[0];
        if (!w_phase[0]) ppuAddr <= ADDR_W'(w_raddr);
      end else if (w_cst_nxt == C_ADDR) begin
        ppuALE  <= 1'b1;
        ppuAddr <= cpuAddr;
      end else if ((w_cst_nxt == C_DATA) && cpuWrite) begin
        ppuWR_n    <= 1'b0;
        ppuDataOE  <= 1'b1;
        ppuDataOut <= cpuWData;
      end else if (w_cst_nxt == C_DATA) begin
        ppuRD_n <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ppu_vram_fetch_sequencer.sv
// ============================================================================
// tb_ppu_vram_fetch_sequencer : directed + randomized bench with a dot-level
// reference model and a VRAM array behind the bus.          Rev 1.0
// ============================================================================
`default_nettype none
module tb_ppu_vram_fetch_sequencer;

  logic        clock = 1'b0;
  logic        reset, clock_EN, backgroundFetch_EN, spriteFetch_EN, dummyFetch_EN;
  logic [14:0] vramAddr;
  logic        bgPatternTable, sprPatternTable, spriteSize16;
  logic [7:0]  spriteTile;
  logic [3:0]  spriteRow;
  logic        cpuReq, cpuWrite;
  logic [13:0] cpuAddr;
  logic [7:0]  cpuWData;
  logic        cpuAck;
  logic [7:0]  cpuRData;
  logic [13:0] ppuAddr;
  logic        ppuALE, ppuRD_n, ppuWR_n, ppuDataOE;
  logic [7:0]  ppuDataOut, ppuDataIn;
  logic [7:0]  ntByte, ptLow, ptHigh, spritePtLow, spritePtHigh;
  logic [1:0]  atBits;
  logic        bgTileValid, spriteDataValid;
  logic [2:0]  spriteIndex;

  logic [7:0]  mem [0:16383];
  assign ppuDataIn = mem[ppuAddr];

  always #5 clock = ~clock;

  ppu_vram_fetch_sequencer #(.ADDR_W(14), .CPU_ABORT_EN(1'b1)) dut (
    .clock(clock), .reset(reset), .clock_EN(clock_EN),
    .backgroundFetch_EN(backgroundFetch_EN), .spriteFetch_EN(spriteFetch_EN),
    .dummyFetch_EN(dummyFetch_EN), .vramAddr(vramAddr),
    .bgPatternTable(bgPatternTable), .sprPatternTable(sprPatternTable),
    .spriteSize16(spriteSize16), .spriteTile(spriteTile), .spriteRow(spriteRow),
    .cpuReq(cpuReq), .cpuWrite(cpuWrite), .cpuAddr(cpuAddr), .cpuWData(cpuWData),
    .cpuAck(cpuAck), .cpuRData(cpuRData), .ppuAddr(ppuAddr), .ppuALE(ppuALE),
    .ppuRD_n(ppuRD_n), .ppuWR_n(ppuWR_n), .ppuDataOut(ppuDataOut),
    .ppuDataOE(ppuDataOE), .ppuDataIn(ppuDataIn), .ntByte(ntByte), .atBits(atBits),
    .ptLow(ptLow), .ptHigh(ptHigh), .bgTileValid(bgTileValid),
    .spritePtLow(spritePtLow), .spritePtHigh(spritePtHigh),
    .spriteIndex(spriteIndex), .spriteDataValid(spriteDataValid)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state; source codes 0=none 1=bg 2=spr 3=dummy, CPU 0=idle 1=addr 2=data.
  int m_psrc, m_ph, m_vlat, m_nt, m_at, m_ptl, m_pth, m_spl, m_sph, m_sidx;
  int m_bgv, m_sv, m_cpu, m_ack, m_rdata, m_pend;
  int e_ale, e_rd, e_wr, e_oe, e_addr, e_dout;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_vec++;
    assert (obs === 32'(exp)) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_psrc = 0; m_ph = 0; m_vlat = 0; m_nt = 0; m_at = 0; m_ptl = 0; m_pth = 0;
    m_spl = 0; m_sph = 0; m_sidx = 0; m_bgv = 0; m_sv = 0; m_cpu = 0; m_ack = 0;
    m_rdata = 0; m_pend = -1;
    e_ale = 0; e_rd = 1; e_wr = 1; e_oe = 0; e_addr = 0; e_dout = 0;
  endtask

  function automatic int render_addr(input int src, input int slot);
    int plane, t, r;
    plane = slot % 2;
    t = int'(spriteTile);
    r = int'(spriteRow);
    if (src == 1) begin
      if (slot == 0) return 'h2000 | (m_vlat & 'hFFF);
      if (slot == 1) return 'h23C0 | (((m_vlat >> 10) & 3) << 10) | (((m_vlat >> 7) & 7) << 3) | ((m_vlat >> 2) & 7);
      return (int'(bgPatternTable) << 12) | (m_nt << 4) | (plane << 3) | ((m_vlat >> 12) & 7);
    end
    if (src == 2 && slot >= 2) begin
      if (spriteSize16)
        return ((t & 1) << 12) | ((t >> 1) << 5) | (((r >> 3) & 1) << 4) | (plane << 3) | (r & 7);
      return (int'(sprPatternTable) << 12) | (t << 4) | (plane << 3) | (r & 7);
    end
    return 'h2000 | (int'(vramAddr) & 'hFFF);
  endfunction

  // One enabled dot: capture last dot's read, advance CPU handshake, then present this dot's bus cycle.
  task automatic model_step();
    int src, ph, d, ps, pslot, old_sv;
    src = dummyFetch_EN ? 3 : backgroundFetch_EN ? 1 : spriteFetch_EN ? 2 : 0;
    ph = (src != m_psrc) ? 0 : m_ph;
    d = int'(mem[e_addr[13:0]]);
    old_sv = m_sv;
    m_bgv = 0;
    m_sv = 0;
    if (m_pend >= 0) begin
      ps = m_pend / 4;
      pslot = m_pend % 4;
      if (ps == 1) begin
        if (pslot == 0) m_nt = d;
        if (pslot == 1) m_at = (d >> (4 * ((m_vlat >> 6) & 1) + 2 * ((m_vlat >> 1) & 1))) & 3;
        if (pslot == 2) m_ptl = d;
        if (pslot == 3) begin m_pth = d; m_bgv = 1; end
      end
      if (ps == 2 && pslot == 2) m_spl = d;
      if (ps == 2 && pslot == 3) begin m_sph = d; m_sv = 1; end
    end
    if (src == 2 && m_psrc != 2) m_sidx = 0;
    else if (old_sv != 0) m_sidx = (m_sidx + 1) % 8;
    m_ack = 0;
    case (m_cpu)
      0: if (src == 0 && cpuReq) m_cpu = 1;
      1: m_cpu = (src != 0) ? 0 : 2;
      default: begin
        if (src == 0) begin
          m_ack = 1;
          if (!cpuWrite) m_rdata = d;
        end
        m_cpu = 0;
      end
    endcase
    m_pend = -1;
    e_ale = 0; e_rd = 1; e_wr = 1; e_oe = 0;
    if (src != 0) begin
      if (src == 1 && ph == 0) m_vlat = int'(vramAddr);
      if (ph % 2 == 0) begin
        e_ale = 1;
        e_addr = render_addr(src, ph / 2);
      end else begin
        e_rd = 0;
        m_pend = src * 4 + ph / 2;
      end
      m_ph = (ph + 1) % 8;
    end else if (m_cpu == 1) begin
      e_ale = 1;
      e_addr = int'(cpuAddr);
    end else if (m_cpu == 2 && cpuWrite) begin
      e_wr = 0; e_oe = 1; e_dout = int'(cpuWData);
    end else if (m_cpu == 2) begin
      e_rd = 0;
    end
    m_psrc = src;
  endtask

  task automatic check_all();
    chk("ppuAddr", 32'(ppuAddr), e_addr);
    chk("ppuALE", 32'(ppuALE), e_ale);
    chk("ppuRD_n", 32'(ppuRD_n), e_rd);
    chk("ppuWR_n", 32'(ppuWR_n), e_wr);
    chk("ppuDataOE", 32'(ppuDataOE), e_oe);
    chk("ppuDataOut", 32'(ppuDataOut), e_dout);
    chk("cpuAck", 32'(cpuAck), m_ack);
    chk("cpuRData", 32'(cpuRData), m_rdata);
    chk("ntByte", 32'(ntByte), m_nt);
    chk("atBits", 32'(atBits), m_at);
    chk("ptLow", 32'(ptLow), m_ptl);
    chk("ptHigh", 32'(ptHigh), m_pth);
    chk("bgTileValid", 32'(bgTileValid), m_bgv);
    chk("spritePtLow", 32'(spritePtLow), m_spl);
    chk("spritePtHigh", 32'(spritePtHigh), m_sph);
    chk("spriteIndex", 32'(spriteIndex), m_sidx);
    chk("spriteDataValid", 32'(spriteDataValid), m_sv);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (clock_EN && !reset) model_step();
    check_all();
  endtask

  initial begin
    int q[$];
    int cnt, cnt2, nt_before;
    logic [14:0] v;
    for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
    mem[14'h2C45] = 8'h5A;
    mem[14'h2FC1] = 8'hE4;
    mem[14'h3F00] = 8'h21;
    reset = 1'b1; clock_EN = 1'b1;
    backgroundFetch_EN = 1'b0; spriteFetch_EN = 1'b0; dummyFetch_EN = 1'b0;
    vramAddr = 15'd0; bgPatternTable = 1'b0; sprPatternTable = 1'b0; spriteSize16 = 1'b0;
    spriteTile = 8'd0; spriteRow = 4'd0;
    cpuReq = 1'b0; cpuWrite = 1'b0; cpuAddr = 14'd0; cpuWData = 8'd0;
    model_reset();
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) tick();

    // Reset in the middle of a CPU write drops the strobe at once and never acks.
    cpuReq = 1'b1; cpuWrite = 1'b1; cpuAddr = 14'($urandom); cpuWData = 8'($urandom);
    tick();
    tick();
    chk("wr_strobe_before_reset", 32'(ppuWR_n), 0);
    #2;
    reset = 1'b1;
    cpuReq = 1'b0;
    model_reset();
    #1;
    chk("reset_wr_n", 32'(ppuWR_n), 1);
    chk("reset_oe", 32'(ppuDataOE), 0);
    check_all();
    tick();
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin tick(); if (cpuAck) cnt++; end
    chk("reset_no_ack", 32'(cnt), 0);

    // Background tile with known NT/AT bytes.
    backgroundFetch_EN = 1'b1; vramAddr = 15'h0C45; bgPatternTable = 1'b1;
    q.delete();
    for (int i = 0; i < 8; i++) begin tick(); if (ppuALE) q.push_back(int'(ppuAddr)); end
    backgroundFetch_EN = 1'b0;
    tick();
    chk("bg_addr_count", 32'(q.size()), 4);
    if (q.size() == 4) begin
      chk("bg_nt_addr", 32'(q[0]), 'h2C45);
      chk("bg_at_addr", 32'(q[1]), 'h2FC1);
      chk("bg_ptl_addr", 32'(q[2]), 'h15A0);
      chk("bg_pth_addr", 32'(q[3]), 'h15A8);
    end
    chk("bg_atBits", 32'(atBits), 2);
    chk("bg_valid_dot9", 32'(bgTileValid), 1);
    tick();

    // Background tile then straight into the sprite window.
    backgroundFetch_EN = 1'b1; vramAddr = 15'($urandom); bgPatternTable = 1'($urandom);
    for (int i = 0; i < 8; i++) tick();
    backgroundFetch_EN = 1'b0; spriteFetch_EN = 1'b1;
    spriteSize16 = 1'b1; spriteTile = 8'h35; spriteRow = 4'd9;
    q.delete();
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      if (i > 0 && i % 8 == 0) begin spriteTile = 8'($urandom); spriteRow = 4'($urandom); end
      tick();
      if (i == 0) chk("spr_phase0_ale", 32'(ppuALE), 1);
      if (i < 8 && ppuALE) q.push_back(int'(ppuAddr));
      if (spriteDataValid) begin chk("spr_valid_index", 32'(spriteIndex), cnt); cnt++; end
    end
    spriteFetch_EN = 1'b0;
    tick();
    if (spriteDataValid) begin chk("spr_valid_index", 32'(spriteIndex), cnt); cnt++; end
    chk("spr_valid_count", 32'(cnt), 8);
    if (q.size() == 4) begin
      chk("spr_ptl_addr", 32'(q[2]), 'h1351);
      chk("spr_pth_addr", 32'(q[3]), 'h1359);
    end else chk("spr_addr_count", 32'(q.size()), 4);

    // CPU read in idle bus time.
    cpuReq = 1'b1; cpuWrite = 1'b0; cpuAddr = 14'h3F00;
    tick();
    chk("cpu_rd_ale", 32'(ppuALE), 1);
    tick();
    chk("cpu_rd_strobe", 32'(ppuRD_n), 0);
    tick();
    chk("cpu_rd_ack", 32'(cpuAck), 1);
    chk("cpu_rd_data", 32'(cpuRData), 'h21);
    if (cpuAck) cpuReq = 1'b0;
    tick();

    // CPU write aborted by a background window, then retried once.
    cpuReq = 1'b1; cpuWrite = 1'b1; cpuAddr = 14'($urandom); cpuWData = 8'($urandom);
    tick();
    backgroundFetch_EN = 1'b1; vramAddr = 15'($urandom);
    cnt = 0; cnt2 = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (!ppuWR_n) cnt2++; if (cpuAck) cnt++; end
    chk("abort_no_wr_strobe", 32'(cnt2), 0);
    backgroundFetch_EN = 1'b0;
    cnt2 = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!ppuWR_n) cnt2++;
      if (cpuAck) begin cnt++; cpuReq = 1'b0; end
    end
    chk("abort_retry_ack_once", 32'(cnt), 1);
    chk("abort_retry_wr_once", 32'(cnt2), 1);

    // Dummy NT fetches latch nothing.
    v = 15'($urandom);
    vramAddr = v; dummyFetch_EN = 1'b1;
    nt_before = int'(ntByte);
    q.delete(); cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ppuALE) q.push_back(int'(ppuAddr));
      if (bgTileValid || spriteDataValid) cnt++;
    end
    dummyFetch_EN = 1'b0;
    tick();
    if (bgTileValid || spriteDataValid) cnt++;
    chk("dummy_addr_count", 32'(q.size()), 2);
    foreach (q[k]) chk("dummy_nt_addr", 32'(q[k]), 'h2000 | int'(v[11:0]));
    chk("dummy_nt_unchanged", 32'(ntByte), nt_before);
    chk("dummy_no_valid", 32'(cnt), 0);

    // Random mix of windows, clock-enable gaps and CPU traffic.
    for (int seg = 0; seg < 40; seg++) begin
      int kind, len;
      kind = $urandom_range(0, 3);
      len = $urandom_range(1, 20);
      dummyFetch_EN = (kind == 3);
      backgroundFetch_EN = (kind == 1) || ((kind == 3) && ($urandom_range(0, 1) == 1));
      spriteFetch_EN = (kind == 2) || ((kind == 1) && ($urandom_range(0, 1) == 1));
      spriteSize16 = 1'($urandom); bgPatternTable = 1'($urandom); sprPatternTable = 1'($urandom);
      for (int i = 0; i < len; i++) begin
        clock_EN = ($urandom_range(0, 4) != 0);
        if (i % 8 == 0) begin
          vramAddr = 15'($urandom); spriteTile = 8'($urandom); spriteRow = 4'($urandom);
        end
        if (!cpuReq && ($urandom_range(0, 2) == 0)) begin
          cpuReq = 1'b1; cpuWrite = 1'($urandom); cpuAddr = 14'($urandom); cpuWData = 8'($urandom);
        end
        tick();
        if (cpuAck) cpuReq = 1'b0;
      end
    end
    clock_EN = 1'b1;
    backgroundFetch_EN = 1'b0; spriteFetch_EN = 1'b0; dummyFetch_EN = 1'b0;
    for (int i = 0; i < 10; i++) begin tick(); if (cpuAck) cpuReq = 1'b0; end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
